// File: rtl/serv_lsu_ctrl_pkg.sv
// Shared types and constants for the bit-serial load/store controller.
//   state_e  : controller FSM states
//   size_e   : access size latched at start
//   wb_req_t : data-bus request payload driven by the controller
package serv_lsu_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_BUS   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam logic [SEL_W-1:0] SEL_BYTE = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_HALF = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_WORD = 4'b1111;

  typedef struct packed {
    logic             cyc;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic [XLEN-1:0]  adr;
    logic [XLEN-1:0]  dat;
  } wb_req_t;

  // Word wins over half; neither means byte.
  function automatic size_e decode_size(input logic word, input logic half);
    size_e sz;
    sz = SZ_BYTE;
    if (word)      sz = SZ_WORD;
    else if (half) sz = SZ_HALF;
    return sz;
  endfunction

  // True when serial bit index idx lies inside the loaded value (not extension).
  function automatic logic bit_in_width(input size_e sz, input logic [CNT_W-1:0] idx);
    logic in_w;
    case (sz)
      SZ_BYTE: in_w = (idx[4:3] == 2'b00);
      SZ_HALF: in_w = ~idx[4];
      default: in_w = 1'b1;
    endcase
    return in_w;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lsb);
    logic mis;
    case (sz)
      SZ_HALF: mis = lsb[0];
      SZ_WORD: mis = |lsb;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/serv_lsu_ctrl_if.sv
// Data-bus interface between the load/store controller and memory.
//   req : request payload (cyc, we, sel, adr, dat) from controller
//   rdt : read data from memory
//   ack : single-cycle acknowledge from memory
interface serv_lsu_ctrl_if;
  import serv_lsu_ctrl_pkg::*;

  wb_req_t         req;
  logic [XLEN-1:0] rdt;
  logic            ack;

  modport master (output req, input rdt, input ack);
  modport slave  (input req, output rdt, output ack);

endinterface

// File: rtl/serv_lsu_lane.sv
// Byte-lane steering for the load/store controller (combinational).
//   size_i, lsb_i : latched access size and address LSBs
//   wdat_i        : collected store data
//   rdt_i         : raw bus read data
//   signed_i      : sign-extend the loaded value
//   sel_o         : byte-lane enables
//   wdat_o        : store data replicated across lanes
//   rdat_o        : read data shifted so the addressed byte sits at bit 0
//   sign_o        : extension bit for the serial load stream
module serv_lsu_lane
  import serv_lsu_ctrl_pkg::*;
(
  input  size_e            size_i,
  input  logic [1:0]       lsb_i,
  input  logic [XLEN-1:0]  wdat_i,
  input  logic [XLEN-1:0]  rdt_i,
  input  logic             signed_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [XLEN-1:0]  wdat_o,
  output logic [XLEN-1:0]  rdat_o,
  output logic             sign_o
);

  always_comb begin
    sel_o  = SEL_BYTE << lsb_i;
    wdat_o = {4{wdat_i[7:0]}};
    rdat_o = rdt_i >> {lsb_i, 3'b000};
    sign_o = signed_i & rdat_o[7];
    case (size_i)
      SZ_WORD: begin
        sel_o  = SEL_WORD;
        wdat_o = wdat_i;
        sign_o = signed_i & rdat_o[31];
      end
      SZ_HALF: begin
        sel_o  = SEL_HALF << lsb_i;
        wdat_o = {2{wdat_i[15:0]}};
        sign_o = signed_i & rdat_o[15];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serv_lsu_ctrl.sv
// Bit-serial load/store controller.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_start..i_signed : op request, sampled in IDLE
//   i_en, i_rs2    : serial step enable and store data (LSB first)
//   i_lsb, i_adr   : address LSBs and word-aligned bus address
//   o_rd           : serial load data (LSB first) in DRAIN
//   o_busy, o_done, o_misalign : status
//   wb             : data-bus master port
module serv_lsu_ctrl
  import serv_lsu_ctrl_pkg::*;
#(
  parameter bit WITH_MISALIGN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_we,
  input  logic            i_word,
  input  logic            i_half,
  input  logic            i_signed,
  input  logic            i_en,
  input  logic            i_rs2,
  input  logic [1:0]      i_lsb,
  input  logic [XLEN-1:0] i_adr,
  output logic            o_rd,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_misalign,
  serv_lsu_ctrl_if.master wb
);

  state_e           state_q;
  size_e            size_q;
  logic [XLEN-1:0]  dat_q;
  logic [XLEN-1:0]  adr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       lsb_q;
  logic             we_q;
  logic             signed_q;
  logic             sign_q;
  logic             cyc_q;
  logic             done_q;
  logic             misalign_q;
  logic             rd_q;

  size_e            size_d;
  logic             misalign_c;
  logic [CNT_W-1:0] cnt_d;
  logic             cnt_last_c;
  logic [SEL_W-1:0] sel_c;
  logic [XLEN-1:0]  wdat_c;
  logic [XLEN-1:0]  rdat_c;
  logic             sign_c;
  wb_req_t          req_c;

  // Request decode at i_start.
  assign size_d     = decode_size(i_word, i_half);
  assign misalign_c = WITH_MISALIGN && is_misaligned(size_d, i_lsb);
  assign cnt_d      = cnt_q + CNT_W'(1);
  assign cnt_last_c = (cnt_q == {CNT_W{1'b1}});

  serv_lsu_lane u_lane (
    .size_i   (size_q),
    .lsb_i    (lsb_q),
    .wdat_i   (dat_q),
    .rdt_i    (wb.rdt),
    .signed_i (signed_q),
    .sel_o    (sel_c),
    .wdat_o   (wdat_c),
    .rdat_o   (rdat_c),
    .sign_o   (sign_c)
  );

  // Controller FSM with counter, shift register and registered status.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      size_q     <= SZ_BYTE;
      dat_q      <= '0;
      adr_q      <= '0;
      cnt_q      <= '0;
      lsb_q      <= '0;
      we_q       <= 1'b0;
      signed_q   <= 1'b0;
      sign_q     <= 1'b0;
      cyc_q      <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            size_q   <= size_d;
            we_q     <= i_we;
            signed_q <= i_signed;
            lsb_q    <= i_lsb;
            cnt_q    <= '0;
            if (misalign_c) begin
              misalign_q <= 1'b1;
            end else if (i_we) begin
              state_q <= ST_FILL;
            end else begin
              state_q <= ST_BUS;
              cyc_q   <= 1'b1;
              adr_q   <= i_adr;
            end
          end
        end
        ST_FILL: begin
          if (i_en) begin
            dat_q <= {i_rs2, dat_q[XLEN-1:1]};
            cnt_q <= cnt_d;
            if (cnt_last_c) begin
              state_q <= ST_BUS;
              cyc_q   <= 1'b1;
              adr_q   <= i_adr;
            end
          end
        end
        ST_BUS: begin
          if (wb.ack) begin
            cyc_q <= 1'b0;
            if (we_q) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
              dat_q   <= rdat_c;
              sign_q  <= sign_c;
              cnt_q   <= '0;
              rd_q    <= rdat_c[0];
            end
          end
        end
        ST_DRAIN: begin
          if (i_en) begin
            dat_q <= dat_q >> 1;
            cnt_q <= cnt_d;
            if (cnt_last_c) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
              rd_q    <= 1'b0;
            end else begin
              // Present the next bit now so o_rd stays a registered output.
              rd_q <= bit_in_width(size_q, cnt_d) ? dat_q[1] : sign_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_c     = '0;
    req_c.cyc = cyc_q;
    req_c.we  = we_q;
    req_c.sel = sel_c;
    req_c.adr = adr_q;
    req_c.dat = wdat_c;
  end

  assign wb.req     = req_c;
  assign o_rd       = rd_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;
  assign o_misalign = misalign_q;

endmodule

// File: tb/tb_serv_lsu_ctrl.sv
// Directed bench for serv_lsu_ctrl: one checking DUT and one with the
// misalignment check disabled.
module tb_serv_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_start, start_nm;
  logic        i_we, i_word, i_half, i_signed, i_en, i_rs2;
  logic [1:0]  i_lsb;
  logic [31:0] i_adr;
  logic        o_rd, o_busy, o_done, o_mis;
  logic        rd_nm, busy_nm, done_nm, mis_nm;

  int n_pass;
  int n_total;

  serv_lsu_ctrl_if bus0 ();
  serv_lsu_ctrl_if bus1 ();

  serv_lsu_ctrl #(.WITH_MISALIGN(1'b1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_we(i_we), .i_word(i_word),
    .i_half(i_half), .i_signed(i_signed), .i_en(i_en), .i_rs2(i_rs2), .i_lsb(i_lsb),
    .i_adr(i_adr), .o_rd(o_rd), .o_busy(o_busy), .o_done(o_done),
    .o_misalign(o_mis), .wb(bus0)
  );

  serv_lsu_ctrl #(.WITH_MISALIGN(1'b0)) u_dut_nm (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_nm), .i_we(i_we), .i_word(i_word),
    .i_half(i_half), .i_signed(i_signed), .i_en(i_en), .i_rs2(i_rs2), .i_lsb(i_lsb),
    .i_adr(i_adr), .o_rd(rd_nm), .o_busy(busy_nm), .o_done(done_nm),
    .o_misalign(mis_nm), .wb(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus drivers (no checking) ----------------
  task automatic start_op(input bit nm, input bit we, input bit word, input bit half,
                          input bit sgn, input logic [1:0] lsb, input logic [31:0] adr);
    i_we = we; i_word = word; i_half = half; i_signed = sgn; i_lsb = lsb; i_adr = adr;
    if (nm) start_nm = 1'b1; else i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0; start_nm = 1'b0;
  endtask

  task automatic fill(input logic [31:0] v, input bit gap);
    for (int i = 0; i < 32; i++) begin
      if (gap) begin i_en = 1'b0; @(negedge clk); end
      i_rs2 = v[i]; i_en = 1'b1;
      @(negedge clk);
    end
    i_en = 1'b0;
  endtask

  task automatic drain(input bit nm, input bit gap, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (gap) begin i_en = 1'b0; @(negedge clk); end
      v[i] = nm ? rd_nm : o_rd;
      i_en = 1'b1;
      @(negedge clk);
    end
    i_en = 1'b0;
  endtask

  task automatic ack_bus(input bit nm, input logic [31:0] rdt);
    if (nm) begin bus1.rdt = rdt; bus1.ack = 1'b1; end
    else    begin bus0.rdt = rdt; bus0.ack = 1'b1; end
    @(negedge clk);
    bus0.ack = 1'b0; bus1.ack = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if ({o_busy, o_done, o_mis, o_rd, bus0.req.cyc} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000", {o_busy, o_done, o_mis, o_rd, bus0.req.cyc});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if ({o_busy, bus0.req.cyc, busy_nm} !== 3'b0)
      $display("FAIL reset_release_idle: got %b want 000", {o_busy, bus0.req.cyc, busy_nm});
    else n_pass++;
  endtask

  task automatic test_store_byte;
    start_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h1000_0040);
    n_total++; if ({o_busy, bus0.req.cyc} !== 2'b10)
      $display("FAIL stb_fill_state: got busy/cyc %b want 10", {o_busy, bus0.req.cyc});
    else n_pass++;
    fill(32'h0000_00A5, 1'b0);
    n_total++; if ({bus0.req.cyc, bus0.req.we, bus0.req.sel} !== 6'b11_0100)
      $display("FAIL stb_cyc_we_sel: got %b want 110100", {bus0.req.cyc, bus0.req.we, bus0.req.sel});
    else n_pass++;
    n_total++; if (bus0.req.adr !== 32'h1000_0040)
      $display("FAIL stb_adr: got %h want 10000040", bus0.req.adr);
    else n_pass++;
    n_total++; if (bus0.req.dat !== 32'hA5A5_A5A5)
      $display("FAIL stb_dat: got %h want a5a5a5a5", bus0.req.dat);
    else n_pass++;
    ack_bus(1'b0, 32'h0);
    n_total++; if ({bus0.req.cyc, o_done} !== 2'b01)
      $display("FAIL stb_done_after_ack: got cyc/done %b want 01", {bus0.req.cyc, o_done});
    else n_pass++;
    @(negedge clk);
    n_total++; if ({o_done, o_busy} !== 2'b00)
      $display("FAIL stb_done_pulse: got done/busy %b want 00", {o_done, o_busy});
    else n_pass++;
  endtask

  task automatic test_load_half;
    logic [31:0] v;
    start_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 32'h2000_0010);
    n_total++; if ({bus0.req.cyc, bus0.req.we, bus0.req.sel} !== 6'b10_1100)
      $display("FAIL ldh_cyc_we_sel: got %b want 101100", {bus0.req.cyc, bus0.req.we, bus0.req.sel});
    else n_pass++;
    ack_bus(1'b0, 32'h8001_1234);
    n_total++; if ({bus0.req.cyc, o_busy} !== 2'b01)
      $display("FAIL ldh_drain_state: got cyc/busy %b want 01", {bus0.req.cyc, o_busy});
    else n_pass++;
    drain(1'b0, 1'b0, v);
    n_total++; if (v !== 32'hFFFF_8001)
      $display("FAIL ldh_signed_value: got %h want ffff8001", v);
    else n_pass++;
    n_total++; if (o_done !== 1'b1)
      $display("FAIL ldh_done: got %b want 1", o_done);
    else n_pass++;
    @(negedge clk);
    start_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h2000_0010);
    ack_bus(1'b0, 32'h8001_1234);
    drain(1'b0, 1'b0, v);
    n_total++; if (v !== 32'h0000_8001)
      $display("FAIL ldh_unsigned_value: got %h want 00008001", v);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_load_byte;
    logic [31:0] v;
    start_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 32'h2000_0020);
    n_total++; if (bus0.req.sel !== 4'b1000)
      $display("FAIL ldb_sel: got %b want 1000", bus0.req.sel);
    else n_pass++;
    ack_bus(1'b0, 32'hF000_0000);
    drain(1'b0, 1'b0, v);
    n_total++; if (v !== 32'h0000_00F0)
      $display("FAIL ldb_unsigned_value: got %h want 000000f0", v);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_misalign;
    logic [31:0] v;
    start_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h3000_0000);
    n_total++; if ({o_mis, o_busy, bus0.req.cyc} !== 3'b100)
      $display("FAIL mis_word_pulse: got mis/busy/cyc %b want 100", {o_mis, o_busy, bus0.req.cyc});
    else n_pass++;
    @(negedge clk);
    n_total++; if ({o_mis, o_busy, bus0.req.cyc} !== 3'b000)
      $display("FAIL mis_word_after: got mis/busy/cyc %b want 000", {o_mis, o_busy, bus0.req.cyc});
    else n_pass++;
    start_op(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'h3000_0000);
    n_total++; if ({o_mis, o_busy} !== 2'b10)
      $display("FAIL mis_half_pulse: got mis/busy %b want 10", {o_mis, o_busy});
    else n_pass++;
    @(negedge clk);
    start_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 32'h3000_0000);
    n_total++; if ({bus1.req.cyc, bus1.req.sel, mis_nm, bus0.req.cyc} !== 7'b1_1111_00)
      $display("FAIL nomis_word_issue: got %b want 1111100", {bus1.req.cyc, bus1.req.sel, mis_nm, bus0.req.cyc});
    else n_pass++;
    ack_bus(1'b1, 32'h1122_3344);
    drain(1'b1, 1'b0, v);
    n_total++; if ({v, done_nm} !== {32'h0011_2233, 1'b1})
      $display("FAIL nomis_word_value: got %h/%b want 00112233/1", v, done_nm);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_gapped;
    logic [31:0] v;
    start_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'h4000_0100);
    fill(32'h1234_5678, 1'b1);
    for (int c = 0; c < 10; c++) begin
      n_total++; if ({bus0.req.cyc, bus0.req.sel, bus0.req.adr, bus0.req.dat} !== {1'b1, 4'b1111, 32'h4000_0100, 32'h1234_5678})
        $display("FAIL gap_store_stable c%0d: got %b %b %h %h want 1 1111 40000100 12345678",
                 c, bus0.req.cyc, bus0.req.sel, bus0.req.adr, bus0.req.dat);
      else n_pass++;
      @(negedge clk);
    end
    ack_bus(1'b0, 32'h0);
    n_total++; if (o_done !== 1'b1)
      $display("FAIL gap_store_done: got %b want 1", o_done);
    else n_pass++;
    @(negedge clk);
    start_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h4000_0200);
    for (int c = 0; c < 10; c++) begin
      n_total++; if ({bus0.req.cyc, bus0.req.sel, bus0.req.adr} !== {1'b1, 4'b1111, 32'h4000_0200})
        $display("FAIL gap_load_stable c%0d: got %b %b %h want 1 1111 40000200",
                 c, bus0.req.cyc, bus0.req.sel, bus0.req.adr);
      else n_pass++;
      @(negedge clk);
    end
    ack_bus(1'b0, 32'hCAFE_BABE);
    drain(1'b0, 1'b1, v);
    n_total++; if ({v, o_done} !== {32'hCAFE_BABE, 1'b1})
      $display("FAIL gap_load_value: got %h/%b want cafebabe/1", v, o_done);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_bus;
    logic [31:0] v;
    start_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h5000_0000);
    n_total++; if (bus0.req.cyc !== 1'b1)
      $display("FAIL rst_bus_entered: got cyc %b want 1", bus0.req.cyc);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({bus0.req.cyc, o_busy} !== 2'b00)
      $display("FAIL rst_cyc_drop: got cyc/busy %b want 00", {bus0.req.cyc, o_busy});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    ack_bus(1'b0, 32'h0000_00FF);
    n_total++; if ({bus0.req.cyc, o_busy, o_done} !== 3'b000)
      $display("FAIL rst_late_ack_ignored: got cyc/busy/done %b want 000", {bus0.req.cyc, o_busy, o_done});
    else n_pass++;
    start_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h5000_0004);
    ack_bus(1'b0, 32'h0000_0080);
    drain(1'b0, 1'b0, v);
    n_total++; if ({v, o_done} !== {32'hFFFF_FF80, 1'b1})
      $display("FAIL rst_next_op: got %h/%b want ffffff80/1", v, o_done);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; i_start = 1'b0; start_nm = 1'b0;
    i_we = 1'b0; i_word = 1'b0; i_half = 1'b0; i_signed = 1'b0;
    i_en = 1'b0; i_rs2 = 1'b0; i_lsb = 2'd0; i_adr = 32'h0;
    bus0.rdt = 32'h0; bus0.ack = 1'b0;
    bus1.rdt = 32'h0; bus1.ack = 1'b0;
    test_reset;
    test_store_byte;
    test_load_half;
    test_load_byte;
    test_misalign;
    test_gapped;
    test_reset_mid_bus;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
